// File: rtl/lcd_pkg.sv
// Shared timing defaults, FSM state codes and long-command list for the
// HD44780-style 4-bit LCD byte writer.
package lcd_pkg;

    localparam int unsigned LCD_SETUP_CYC     = 2;
    localparam int unsigned LCD_E_HIGH_CYC    = 12;
    localparam int unsigned LCD_NIB_GAP_CYC   = 50;
    localparam int unsigned LCD_CMD_WAIT_CYC  = 2000;
    localparam int unsigned LCD_LONG_WAIT_CYC = 82000;

    localparam int unsigned LCD_CNT_W = 17;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP_H = 3'd1;
    localparam logic [2:0] ST_E_H     = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_SETUP_L = 3'd4;
    localparam logic [2:0] ST_E_L     = 3'd5;
    localparam logic [2:0] ST_WAIT    = 3'd6;

    // Clear display (0x01) and return home (0x02/0x03) need the long post-byte wait.
    localparam logic [2:0][7:0] LCD_LONG_CMDS = {8'h03, 8'h02, 8'h01};

    function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!rs && (b == LCD_LONG_CMDS[i[1:0]])) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one command/character byte to the LCD as two 4-bit nibbles with
// enable pulse timing and a post-byte busy wait; one byte at a time.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = LCD_SETUP_CYC,
    parameter int unsigned E_HIGH_CYC    = LCD_E_HIGH_CYC,
    parameter int unsigned NIB_GAP_CYC   = LCD_NIB_GAP_CYC,
    parameter int unsigned CMD_WAIT_CYC  = LCD_CMD_WAIT_CYC,
    parameter int unsigned LONG_WAIT_CYC = LCD_LONG_WAIT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    output logic       in_ready,
    output logic       busy,
    output logic [3:0] data,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       SF_CE0
);

    // Counter holds (cycles - 1) on state entry; the state ends when it reads zero.
    localparam logic [LCD_CNT_W-1:0] SETUP_LOAD = LCD_CNT_W'(SETUP_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] E_LOAD     = LCD_CNT_W'(E_HIGH_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] GAP_LOAD   = LCD_CNT_W'(NIB_GAP_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] CMD_LOAD   = LCD_CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] LONG_LOAD  = LCD_CNT_W'(LONG_WAIT_CYC - 1);

    logic [2:0]           state_q, state_d;
    logic [LCD_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic                 brs_q, brs_d;
    logic [3:0]           data_q, data_d;
    logic                 e_q, e_d;
    logic                 rs_q, rs_d;
    logic                 ready_q, ready_d;
    logic                 done;

    assign done = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        brs_d   = brs_q;
        data_d  = data_q;
        e_d     = e_q;
        rs_d    = rs_q;
        ready_d = ready_q;
        if (!done) cnt_d = cnt_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                cnt_d   = '0;
                if (in_valid && ready_q) begin
                    byte_d  = in_data;
                    brs_d   = in_rs;
                    data_d  = in_data[7:4];
                    rs_d    = in_rs;
                    ready_d = 1'b0;
                    state_d = ST_SETUP_H;
                    cnt_d   = SETUP_LOAD;
                end
            end
            ST_SETUP_H: if (done) begin
                state_d = ST_E_H;
                e_d     = 1'b1;
                cnt_d   = E_LOAD;
            end
            ST_E_H: if (done) begin
                state_d = ST_GAP;
                e_d     = 1'b0;
                cnt_d   = GAP_LOAD;
            end
            ST_GAP: if (done) begin
                state_d = ST_SETUP_L;
                data_d  = byte_q[3:0];
                cnt_d   = SETUP_LOAD;
            end
            ST_SETUP_L: if (done) begin
                state_d = ST_E_L;
                e_d     = 1'b1;
                cnt_d   = E_LOAD;
            end
            ST_E_L: if (done) begin
                state_d = ST_WAIT;
                e_d     = 1'b0;
                cnt_d   = is_long_cmd(byte_q, brs_q) ? LONG_LOAD : CMD_LOAD;
            end
            ST_WAIT: if (done) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                e_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            brs_q   <= 1'b0;
            data_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            brs_q   <= brs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready = ready_q;
    assign busy     = ~ready_q;
    assign data     = data_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign SF_CE0   = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Randomized bench for lcd_byte_writer against a timeline reference model.
module tb_lcd_byte_writer;

    localparam int S    = 2;
    localparam int EH   = 12;
    localparam int G    = 50;
    localparam int CW   = 2000;
    localparam int LW   = 4000;
    localparam int LO_AT = S + EH + G;          // edge where low nibble appears
    localparam int XFER  = 2 * S + 2 * EH + G;  // edge where lcd_e falls the second time

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_rs = 1'b0;
    logic       in_ready, busy, lcd_e, lcd_rw, lcd_rs, SF_CE0;
    logic [3:0] data;

    lcd_byte_writer #(
        .SETUP_CYC    (S),
        .E_HIGH_CYC   (EH),
        .NIB_GAP_CYC  (G),
        .CMD_WAIT_CYC (CW),
        .LONG_WAIT_CYC(LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_rs   (in_rs),
        .in_ready(in_ready),
        .busy    (busy),
        .data    (data),
        .lcd_e   (lcd_e),
        .lcd_rw  (lcd_rw),
        .lcd_rs  (lcd_rs),
        .SF_CE0  (SF_CE0)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time since accept (k) decides every output.
    bit         m_ready  = 1'b0;
    bit         m_active = 1'b0;
    int         k = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_rs = 1'b0;
    logic [3:0] m_data = 4'h0;
    int         n_accepts = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wait_len();
        return (!m_rs && (m_byte inside {8'h01, 8'h02, 8'h03})) ? LW : CW;
    endfunction

    function automatic logic exp_e();
        return m_active && ((k >= S && k < S + EH) || (k >= LO_AT + S && k < XFER));
    endfunction

    task automatic model_reset();
        m_ready  = 1'b0;
        m_active = 1'b0;
        m_data   = 4'h0;
        m_rs     = 1'b0;
        k        = 0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (m_ready) begin
            if (in_valid) begin
                m_active = 1'b1;
                k        = 0;
                m_byte   = in_data;
                m_rs     = in_rs;
                m_data   = in_data[7:4];
                m_ready  = 1'b0;
                n_accepts++;
            end
        end else if (!m_active) begin
            m_ready = 1'b1;
        end else begin
            k++;
            if (k == LO_AT) m_data = m_byte[3:0];
            if (k == XFER + wait_len()) begin
                m_ready  = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("in_ready", in_ready, m_ready);
        check_val("busy", busy, !m_ready);
        check_val("data", data, m_data);
        check_val("lcd_e", lcd_e, exp_e());
        check_val("lcd_rs", lcd_rs, m_rs);
        check_val("lcd_rw", lcd_rw, 1'b0);
        check_val("SF_CE0", SF_CE0, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        int start;
        int n;
        start    = n_accepts;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_rs    = rs;
        while (n_accepts == start && n < 10000) begin
            step();
            n++;
        end
        if (n_accepts == start) check_val("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until the DUT raises in_ready.
    task automatic measure_ready(input string tag, input int exp);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10000) begin
            step();
            n++;
        end
        check_val(tag, n, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!m_ready && n < 10000) begin
            step();
            n++;
        end
        if (!m_ready) check_val("idle_timeout", 0, 1);
    endtask

    initial begin
        int start;
        int n;

        #1 rst = 1'b1;
        #2;
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_busy", busy, 1'b1);
        check_val("rst_data", data, 4'h0);
        check_val("rst_lcd_e", lcd_e, 1'b0);
        check_val("rst_lcd_rs", lcd_rs, 1'b0);
        check_val("rst_SF_CE0", SF_CE0, 1'b1);
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        check_val("ready_after_por", in_ready, 1'b1);

        // Directed bytes with known ready edges
        send_byte(8'h28, 1'b0);
        measure_ready("ready_28_cmd", XFER + CW);
        send_byte(8'h49, 1'b1);
        measure_ready("ready_49_data", XFER + CW);
        send_byte(8'h01, 1'b0);
        measure_ready("ready_01_cmd", XFER + LW);
        send_byte(8'h01, 1'b1);
        measure_ready("ready_01_data", XFER + CW);
        step();

        // Back-to-back with in_valid held high
        start    = n_accepts;
        in_valid = 1'b1;
        in_data  = 8'h0C;
        in_rs    = 1'b0;
        n = 0;
        while (n_accepts == start && n < 100) begin step(); n++; end
        in_data = 8'h06;
        n = 0;
        while (n_accepts == start + 1 && n < 10000) begin step(); n++; end
        check_val("b2b_second_accept_edge", n, XFER + CW + 1);
        in_valid = 1'b0;
        wait_idle();
        step();
        check_val("b2b_accept_count", n_accepts - start, 2);

        // Reset while lcd_e is high in the low-nibble pulse
        send_byte(8'h33, 1'b1);
        n = 0;
        while (k < 70 && n < 200) begin step(); n++; end
        check_val("mid_e_high", lcd_e, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_lcd_e", lcd_e, 1'b0);
        check_val("mid_rst_data", data, 4'h0);
        check_val("mid_rst_in_ready", in_ready, 1'b0);
        check_val("mid_rst_SF_CE0", SF_CE0, 1'b1);
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
        check_val("ready_after_mid_rst", in_ready, 1'b1);

        // Random traffic, including in_valid while busy
        for (int c = 0; c < 25000; c++) begin
            in_valid = ($urandom_range(0, 9) == 0);
            in_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            in_rs    = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        wait_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
